cw305_mailbox_ctrl: RTL and testbench

Message-framed mailbox controller between the CW305 host register interface and the PULPino core, in the `crypto_clk` domain. Host→core words are collected into a FIFO under a length-header state machine, and the core is interrupted when a full message has arrived. Core→host words go through a second FIFO, together with a sticky "done" flag. A packed status word feeds the register block's `REG_DATA_STATUS` read path. All host-side inputs arrive already synchronised to `crypto_clk`.

---
 rtl/cw305_mailbox_ctrl_pkg.sv | 14 +
 rtl/cw305_mbox_fifo.sv | 41 ++++
 rtl/cw305_mailbox_ctrl.sv | 90 +++++++++
 tb/tb_cw305_mailbox_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cw305_mailbox_ctrl_pkg.sv
// cw305_mailbox_ctrl_pkg: FSM state encodings, status bit positions and header length field bounds
package cw305_mailbox_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, NOTIFY = 2'd2} state_t;
  localparam int ST_H2C_LSB = 0;
  localparam int ST_C2H_LSB = 8;
  localparam int ST_STATE_LSB = 16;
  localparam int ST_OVF = 20;
  localparam int ST_PROTO_ERR = 21;
  localparam int ST_LEN_ERR = 22;
  localparam int ST_DONE = 23;
  localparam int ST_IRQ = 24;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 0;
endpackage

// File: rtl/cw305_mbox_fifo.sv
// cw305_mbox_fifo: first-word fall-through FIFO (push/pop/flush in, rdata/avail/full/level out)
module cw305_mbox_fifo #(
  parameter int pDEPTH = 8,
  parameter int pWIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [pWIDTH-1:0]         wdata,
  output logic [pWIDTH-1:0]         rdata,
  output logic                      avail,
  output logic                      full,
  output logic [$clog2(pDEPTH):0]   level
);
  localparam int AW = $clog2(pDEPTH);
  localparam int LW = AW + 1;
  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign avail = level != '0;
  assign full = level == LW'(pDEPTH);
  assign do_pop = pop & avail & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign rdata = avail ? mem[rptr] : '0;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/cw305_mailbox_ctrl.sv
// cw305_mailbox_ctrl: host/core mailbox with length-framed h2c FIFO, c2h FIFO, sticky flags and packed status
module cw305_mailbox_ctrl
  import cw305_mailbox_ctrl_pkg::*;
#(
  parameter int pDEPTH = 8,
  parameter int pWIDTH = 32
) (
  input  logic              crypto_clk,
  input  logic              reset_i,
  input  logic              host_push,
  input  logic [pWIDTH-1:0] host_wdata,
  input  logic              host_pop,
  output logic [pWIDTH-1:0] host_rdata,
  output logic              host_avail,
  input  logic              host_flush,
  input  logic              host_clear,
  input  logic              core_pop,
  output logic [pWIDTH-1:0] core_rdata,
  output logic              core_avail,
  input  logic              core_push,
  input  logic [pWIDTH-1:0] core_wdata,
  input  logic              core_done,
  output logic              core_msg_irq,
  input  logic              core_msg_ack,
  output logic [31:0]       status
);
  localparam int LW = $clog2(pDEPTH) + 1;
  state_t state;
  logic [7:0] rem, hdr_len;
  logic ovf, proto_err, len_err, done_flag;
  logic h2c_full, c2h_full, h2c_push, h2c_drop, c2h_drop, push_ok;
  logic [LW-1:0] h2c_level, c2h_level;
  assign hdr_len = host_wdata[HDR_LEN_MSB:HDR_LEN_LSB];
  assign push_ok = host_push & ~host_flush;
  assign h2c_push = push_ok & (state == RECV);
  assign h2c_drop = h2c_push & h2c_full & ~core_pop;
  assign c2h_drop = core_push & c2h_full & ~host_pop;
  cw305_mbox_fifo #(.pDEPTH(pDEPTH), .pWIDTH(pWIDTH)) u_h2c (
    .clk(crypto_clk), .rst(reset_i), .push(h2c_push), .pop(core_pop), .flush(host_flush),
    .wdata(host_wdata), .rdata(core_rdata), .avail(core_avail), .full(h2c_full), .level(h2c_level)
  );
  cw305_mbox_fifo #(.pDEPTH(pDEPTH), .pWIDTH(pWIDTH)) u_c2h (
    .clk(crypto_clk), .rst(reset_i), .push(core_push), .pop(host_pop), .flush(1'b0),
    .wdata(core_wdata), .rdata(host_rdata), .avail(host_avail), .full(c2h_full), .level(c2h_level)
  );
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      state <= IDLE;
      rem <= '0;
      core_msg_irq <= 1'b0;
      ovf <= 1'b0;
      proto_err <= 1'b0;
      len_err <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      ovf <= ~host_clear & (ovf | h2c_drop | c2h_drop);
      proto_err <= ~host_clear & (proto_err | (push_ok & (state == NOTIFY)));
      len_err <= ~host_clear & (len_err | (push_ok & (state == IDLE) & (hdr_len == '0)));
      done_flag <= core_done | (done_flag & ~host_clear);
      if (host_flush) begin
        state <= IDLE;
        rem <= '0;
        core_msg_irq <= 1'b0;
      end else if (state == IDLE && host_push && hdr_len != '0) begin
        state <= RECV;
        rem <= hdr_len;
      end else if (state == RECV && host_push) begin
        rem <= rem - 8'd1;
        if (rem == 8'd1) begin
          state <= NOTIFY;
          core_msg_irq <= 1'b1;
        end
      end else if (state == NOTIFY && core_msg_ack) begin
        state <= IDLE;
        core_msg_irq <= 1'b0;
      end
    end
  end
  always_comb begin
    status = '0;
    status[ST_H2C_LSB +: 5] = 5'(h2c_level);
    status[ST_C2H_LSB +: 5] = 5'(c2h_level);
    status[ST_STATE_LSB +: 2] = state;
    status[ST_OVF] = ovf;
    status[ST_PROTO_ERR] = proto_err;
    status[ST_LEN_ERR] = len_err;
    status[ST_DONE] = done_flag;
    status[ST_IRQ] = core_msg_irq;
  end
endmodule

// File: tb/tb_cw305_mailbox_ctrl.sv
// tb_cw305_mailbox_ctrl: directed and randomized checks of the mailbox against a queue-based model
module tb_cw305_mailbox_ctrl;
  localparam int D = 8;
  logic crypto_clk = 0, reset_i = 0;
  logic host_push = 0, host_pop = 0, host_flush = 0, host_clear = 0;
  logic core_pop = 0, core_push = 0, core_done = 0, core_msg_ack = 0;
  logic [31:0] host_wdata = 0, core_wdata = 0;
  logic [31:0] host_rdata, core_rdata, status;
  logic host_avail, core_avail, core_msg_irq;
  int n_chk = 0, n_fail = 0;
  bit started = 0;
  cw305_mailbox_ctrl #(.pDEPTH(D), .pWIDTH(32)) dut (
    .crypto_clk(crypto_clk), .reset_i(reset_i), .host_push(host_push), .host_wdata(host_wdata),
    .host_pop(host_pop), .host_rdata(host_rdata), .host_avail(host_avail), .host_flush(host_flush),
    .host_clear(host_clear), .core_pop(core_pop), .core_rdata(core_rdata), .core_avail(core_avail),
    .core_push(core_push), .core_wdata(core_wdata), .core_done(core_done), .core_msg_irq(core_msg_irq),
    .core_msg_ack(core_msg_ack), .status(status)
  );
  always #5 crypto_clk = ~crypto_clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  logic [31:0] mq_h[$], mq_c[$];
  int m_mode = 0, m_rem = 0;
  bit m_ovf = 0, m_pe = 0, m_le = 0, m_done = 0, os, ps, ls, hp;
  int pm;
  always @(posedge crypto_clk) begin
    if (reset_i) begin
      mq_h.delete();
      mq_c.delete();
      m_mode = 0;
      m_rem = 0;
      {m_ovf, m_pe, m_le, m_done} = 4'b0;
    end else begin
      os = 0; ps = 0; ls = 0;
      pm = m_mode;
      hp = host_push && !host_flush;
      if (host_flush) mq_h.delete();
      else begin
        if (core_pop && mq_h.size() > 0) void'(mq_h.pop_front());
        if (hp && pm == 1) begin
          if (mq_h.size() < D) mq_h.push_back(host_wdata); else os = 1;
        end
      end
      if (host_pop && mq_c.size() > 0) void'(mq_c.pop_front());
      if (core_push) begin
        if (mq_c.size() < D) mq_c.push_back(core_wdata); else os = 1;
      end
      if (host_flush) begin
        m_mode = 0;
        m_rem = 0;
      end else begin
        if (hp && pm == 0) begin
          if (host_wdata[7:0] == 0) ls = 1;
          else begin m_mode = 1; m_rem = int'(host_wdata[7:0]); end
        end
        if (hp && pm == 1) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_mode = 2;
        end
        if (hp && pm == 2) ps = 1;
        if (pm == 2 && core_msg_ack) m_mode = 0;
      end
      m_ovf = !host_clear && (m_ovf || os);
      m_pe = !host_clear && (m_pe || ps);
      m_le = !host_clear && (m_le || ls);
      m_done = core_done || (m_done && !host_clear);
    end
  end
  function automatic logic [31:0] exp_status();
    return 32'(mq_h.size()) | (32'(mq_c.size()) << 8) | (32'(m_mode) << 16) | (32'(m_ovf) << 20)
         | (32'(m_pe) << 21) | (32'(m_le) << 22) | (32'(m_done) << 23) | (32'(m_mode == 2) << 24);
  endfunction
  always @(negedge crypto_clk) begin
    if (started) begin
      chk("m_status", status, exp_status());
      chk("m_irq", 32'(core_msg_irq), 32'(m_mode == 2));
      chk("m_core_avail", 32'(core_avail), 32'(mq_h.size() > 0));
      chk("m_host_avail", 32'(host_avail), 32'(mq_c.size() > 0));
      chk("m_core_rdata", core_rdata, mq_h.size() > 0 ? mq_h[0] : 32'h0);
      chk("m_host_rdata", host_rdata, mq_c.size() > 0 ? mq_c[0] : 32'h0);
    end
  end
  task automatic tick();
    @(posedge crypto_clk);
    #1;
    {reset_i, host_push, host_pop, host_flush, host_clear, core_pop, core_push, core_done, core_msg_ack} = '0;
  endtask
  task automatic push_h(input logic [31:0] v);
    host_push = 1;
    host_wdata = v;
    tick();
  endtask
  initial begin
    reset_i = 1;
    tick();
    started = 1;
    chk("rst_status", status, 32'h0);
    chk("rst_avail", {30'b0, host_avail, core_avail}, 32'h0);
    chk("rst_irq", 32'(core_msg_irq), 32'h0);
    push_h(32'h3);
    chk("hdr_state", 32'(status[17:16]), 32'h1);
    push_h(32'hA);
    push_h(32'hB);
    push_h(32'hC);
    chk("basic_irq", 32'(core_msg_irq), 32'h1);
    chk("basic_state", 32'(status[17:16]), 32'h2);
    chk("basic_level", 32'(status[4:0]), 32'h3);
    chk("basic_head", core_rdata, 32'hA);
    core_pop = 1; tick();
    chk("basic_pop1", core_rdata, 32'hB);
    core_pop = 1; tick();
    chk("basic_pop2", core_rdata, 32'hC);
    core_pop = 1; tick();
    chk("basic_empty", 32'(core_avail), 32'h0);
    core_msg_ack = 1; tick();
    chk("ack_irq", 32'(core_msg_irq), 32'h0);
    chk("ack_state", 32'(status[17:16]), 32'h0);
    push_h(32'h0);
    chk("zlen_state", 32'(status[17:16]), 32'h0);
    chk("zlen_err", 32'(status[22]), 32'h1);
    host_clear = 1; tick();
    chk("zlen_clear", 32'(status[22]), 32'h0);
    push_h(32'hA);
    for (int i = 0; i < 10; i++) push_h(32'h100 + 32'(i));
    chk("ovf_level", 32'(status[4:0]), 32'h8);
    chk("ovf_flag", 32'(status[20]), 32'h1);
    chk("ovf_irq", 32'(core_msg_irq), 32'h1);
    chk("ovf_head", core_rdata, 32'h100);
    core_msg_ack = 1; tick();
    host_clear = 1; tick();
    chk("ovf_clear", 32'(status[20]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      core_push = 1; core_wdata = 32'h200 + 32'(i); tick();
    end
    chk("c2h_full", 32'(status[12:8]), 32'h8);
    chk("c2h_head", host_rdata, 32'h200);
    core_push = 1; core_wdata = 32'h2FF; host_pop = 1; tick();
    chk("c2h_sim_level", 32'(status[12:8]), 32'h8);
    chk("c2h_sim_ovf", 32'(status[20]), 32'h0);
    chk("c2h_sim_head", host_rdata, 32'h201);
    push_h(32'hA);
    chk("h2c_recv", 32'(status[17:16]), 32'h1);
    host_push = 1; host_wdata = 32'h300; core_pop = 1; tick();
    chk("h2c_sim_level", 32'(status[4:0]), 32'h8);
    chk("h2c_sim_ovf", 32'(status[20]), 32'h0);
    chk("h2c_sim_head", core_rdata, 32'h101);
    host_flush = 1; host_push = 1; host_wdata = 32'h301; tick();
    chk("flush_level", 32'(status[4:0]), 32'h0);
    chk("flush_state", 32'(status[17:16]), 32'h0);
    push_h(32'h2);
    host_push = 1; host_wdata = 32'h400; core_pop = 1; tick();
    chk("empty_sim_level", 32'(status[4:0]), 32'h1);
    chk("empty_sim_head", core_rdata, 32'h400);
    push_h(32'h401);
    chk("msg2_irq", 32'(core_msg_irq), 32'h1);
    push_h(32'h402);
    chk("proto_err", 32'(status[21]), 32'h1);
    chk("proto_level", 32'(status[4:0]), 32'h2);
    core_done = 1; host_clear = 1; tick();
    chk("race_done", 32'(status[23]), 32'h1);
    chk("race_proto", 32'(status[21]), 32'h0);
    core_msg_ack = 1; tick();
    push_h(32'h5);
    push_h(32'h500);
    reset_i = 1; tick();
    chk("mrst_status", status, 32'h0);
    chk("mrst_avail", {30'b0, host_avail, core_avail}, 32'h0);
    chk("mrst_rdata", host_rdata | core_rdata, 32'h0);
    chk("mrst_irq", 32'(core_msg_irq), 32'h0);
    for (int i = 0; i < 4000; i++) begin
      reset_i = $urandom_range(0, 599) == 0;
      host_push = $urandom_range(0, 2) == 0;
      host_wdata = $urandom();
      host_wdata[7:0] = 8'($urandom_range(0, 12));
      host_pop = $urandom_range(0, 2) == 0;
      core_pop = $urandom_range(0, 2) == 0;
      core_push = $urandom_range(0, 3) == 0;
      core_wdata = $urandom();
      host_flush = $urandom_range(0, 79) == 0;
      host_clear = $urandom_range(0, 39) == 0;
      core_done = $urandom_range(0, 19) == 0;
      core_msg_ack = $urandom_range(0, 3) == 0;
      tick();
    end
    @(negedge crypto_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
